// File: rtl/dffnsre_8lut_bank.sv
// rtl/dffnsre_8lut_bank.sv - eight falling-edge DFFNSRE lanes, each fed by a pass/invert LUT
module dffnsre_8lut_bank (
  input  logic C,
  input  logic R,
  input  logic S,
  input  logic E,
  input  logic sel,
  input  logic D_in1,
  input  logic D_in2,
  input  logic D_in3,
  input  logic D_in4,
  input  logic D_in5,
  input  logic D_in6,
  input  logic D_in7,
  input  logic D_in8,
  output logic Q_1,
  output logic Q_2,
  output logic Q_3,
  output logic Q_4,
  output logic Q_5,
  output logic Q_6,
  output logic Q_7,
  output logic Q_8
);

  logic [7:0] d_raw;
  logic [7:0] d_lut;
  logic [7:0] q_r;

  // Bit i-1 carries lane i throughout.
  assign d_raw = {D_in8, D_in7, D_in6, D_in5, D_in4, D_in3, D_in2, D_in1};

  always_comb begin
    d_lut = sel ? d_raw : ~d_raw;
  end

  // Reset outranks set; both are level-sensitive and bypass the clock.
  always_ff @(negedge C or negedge R or negedge S) begin
    if (!R) begin
      q_r <= 8'h00;
    end else if (!S) begin
      q_r <= 8'hff;
    end else if (E) begin
      q_r <= d_lut;
    end
  end

  assign Q_1 = q_r[0];
  assign Q_2 = q_r[1];
  assign Q_3 = q_r[2];
  assign Q_4 = q_r[3];
  assign Q_5 = q_r[4];
  assign Q_6 = q_r[5];
  assign Q_7 = q_r[6];
  assign Q_8 = q_r[7];

endmodule

// File: tb/tb_dffnsre_8lut_bank.sv
// tb/tb_dffnsre_8lut_bank.sv - directed and random checks of the DFFNSRE LUT bank
module tb_dffnsre_8lut_bank;

  logic       C = 1'b0;
  logic       R;
  logic       S;
  logic       E;
  logic       sel;
  logic [7:0] d_vec;
  logic       Q_1, Q_2, Q_3, Q_4, Q_5, Q_6, Q_7, Q_8;
  logic [7:0] q_obs;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_q;
  logic [7:0] pat;

  always #5 C = ~C;

  assign q_obs = {Q_8, Q_7, Q_6, Q_5, Q_4, Q_3, Q_2, Q_1};

  dffnsre_8lut_bank dut (
    .C(C), .R(R), .S(S), .E(E), .sel(sel),
    .D_in1(d_vec[0]), .D_in2(d_vec[1]), .D_in3(d_vec[2]), .D_in4(d_vec[3]),
    .D_in5(d_vec[4]), .D_in6(d_vec[5]), .D_in7(d_vec[6]), .D_in8(d_vec[7]),
    .Q_1(Q_1), .Q_2(Q_2), .Q_3(Q_3), .Q_4(Q_4),
    .Q_5(Q_5), .Q_6(Q_6), .Q_7(Q_7), .Q_8(Q_8)
  );

  // Turns a pattern written lane 1 first into a vector indexed by lane-1.
  function automatic logic [7:0] lanes(input logic [7:0] written);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = written[7-i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [7:0] expected);
    n_assert++;
    assert (q_obs === expected) else begin
      n_fail++;
      $error("FAIL %s: Q_8..Q_1=%b expected %b", tag, q_obs, expected);
    end
  endtask

  initial begin
    // Reset asserted, no clock edge needed
    R = 1'b0; S = 1'b1; E = 1'b0; sel = 1'b0; d_vec = 8'h00;
    #2 check("reset_immediate", 8'h00);
    #12 check("reset_after_edges", 8'h00);

    // Enabled edges while R=0 must not capture
    E = 1'b1; sel = 1'b1; d_vec = 8'hff;
    @(posedge C); #1 check("reset_beats_clock", 8'h00);

    // Release reset, hold with E=0
    E = 1'b0;
    #1 R = 1'b1;
    #1 check("reset_release_holds", 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge C); #1 check("hold_e0", 8'h00);
    end

    // Pass mode capture, and no combinational path to Q
    pat = lanes(8'b10110010);
    @(posedge C); E = 1'b1; sel = 1'b1; d_vec = pat;
    #1 check("no_comb_path", 8'h00);
    @(posedge C); #1 check("pass_capture", pat);

    // Invert mode capture
    sel = 1'b0;
    @(posedge C); #1 check("invert_capture", lanes(8'b01001101));

    // sel toggling between edges has no effect
    @(negedge C); #1 sel = 1'b1;
    #1 check("sel_between_edges", lanes(8'b01001101));
    #1 sel = 1'b0;
    @(posedge C); #1 check("sel_restored", lanes(8'b01001101));

    // Disabled edge holds with changed data
    E = 1'b0; sel = 1'b1; d_vec = 8'h5a;
    @(posedge C); #1 check("hold_new_data", lanes(8'b01001101));

    // Async set mid-cycle, then reset overrides set
    #2 S = 1'b0;
    #1 check("set_immediate", 8'hff);
    #1 R = 1'b0;
    #1 check("reset_beats_set", 8'h00);
    S = 1'b1;
    #1 check("reset_alone", 8'h00);
    R = 1'b1; E = 1'b1; sel = 1'b1; d_vec = 8'h00;
    @(posedge C); #1 check("release_capture_zero", 8'h00);

    // Set released: value held across a disabled edge, then replaced
    E = 1'b0; d_vec = 8'h3c;
    #1 S = 1'b0;
    #1 S = 1'b1;
    #1 check("set_release_holds", 8'hff);
    @(posedge C); #1 check("set_hold_e0", 8'hff);
    E = 1'b1;
    @(posedge C); #1 check("set_then_capture", 8'h3c);

    // Random soak, pass mode with enable
    E = 1'b1; sel = 1'b1;
    for (int k = 0; k < 16; k++) begin
      d_vec = 8'($urandom);
      exp_q = d_vec;
      @(posedge C); #1 check("soak_pass", exp_q);
    end

    // Random soak with random enable and select
    for (int k = 0; k < 24; k++) begin
      d_vec = 8'($urandom);
      E     = 1'($urandom);
      sel   = 1'($urandom);
      if (E) exp_q = sel ? d_vec : ~d_vec;
      @(posedge C); #1 check("soak_mixed", exp_q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
